// File: rtl/mdlu_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: function codes,
// FSM state type and the default datapath width.
package mdlu_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [5:0] FUNC_MFHI  = 6'h10;
    localparam logic [5:0] FUNC_MTHI  = 6'h11;
    localparam logic [5:0] FUNC_MFLO  = 6'h12;
    localparam logic [5:0] FUNC_MTLO  = 6'h13;
    localparam logic [5:0] FUNC_MULT  = 6'h18;
    localparam logic [5:0] FUNC_MULTU = 6'h19;
    localparam logic [5:0] FUNC_DIV   = 6'h1A;
    localparam logic [5:0] FUNC_DIVU  = 6'h1B;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        DIV,
        FIX,
        DONE
    } state_t;

    function automatic logic is_mul_func(input logic [5:0] f);
        return (f == FUNC_MULT) || (f == FUNC_MULTU);
    endfunction

    function automatic logic is_div_func(input logic [5:0] f);
        return (f == FUNC_DIV) || (f == FUNC_DIVU);
    endfunction

endpackage

// File: rtl/mdlu_step.sv
// One combinational iteration: shift-add multiply step, or (with MDLU_DIV_EN)
// one restoring-division step, over unsigned operand magnitudes.
module mdlu_step
    import mdlu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
`ifdef MDLU_DIV_EN
    input  logic             is_div,
`endif
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] quo_next
);

    // Multiply: {acc,quo} shifts right; the multiplier drains out of quo while
    // product bits fill it from the top.
    logic [WIDTH:0] sum;
    assign sum = {1'b0, acc} + (quo[0] ? {1'b0, opnd} : '0);

`ifdef MDLU_DIV_EN
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             ge;

    // A successful subtract always leaves a remainder below the divisor, so the
    // low WIDTH bits of the difference are exact.
    assign shifted = {acc, quo[WIDTH-1]};
    assign ge      = shifted >= {1'b0, opnd};
    assign diff    = shifted[WIDTH-1:0] - opnd;

    always_comb begin
        if (is_div) begin
            acc_next = ge ? diff : shifted[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], ge};
        end else begin
            acc_next = sum[WIDTH:1];
            quo_next = {sum[0], quo[WIDTH-1:1]};
        end
    end
`else
    assign acc_next = sum[WIDTH:1];
    assign quo_next = {sum[0], quo[WIDTH-1:1]};
`endif

endmodule

// File: rtl/mdlu_sequencer.sv
// Iterative HI/LO multiply/divide unit with MTHI/MTLO/MFHI/MFLO access.
// Divide support is compiled in only when MDLU_DIV_EN is defined.
module mdlu_sequencer
    import mdlu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       func,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] resultOutput,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             state, state_next;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   acc, quo, opnd;
    logic [WIDTH-1:0]   acc_step, quo_step;
    logic               neg_q;
    logic               idle, last_step;
    logic               accept_mul, accept_div;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] product;

    assign idle       = (state == IDLE);
    assign last_step  = (cnt == CW'(WIDTH - 1));
    assign accept_mul = idle && start && is_mul_func(func);
`ifdef MDLU_DIV_EN
    logic op_div, neg_r;
    assign accept_div = idle && start && is_div_func(func);
`else
    assign accept_div = 1'b0;
`endif

    // The iteration runs on magnitudes; signs are reapplied in FIX.
    assign a_neg = ((func == FUNC_MULT) || (func == FUNC_DIV)) && operandA[WIDTH-1];
    assign b_neg = ((func == FUNC_MULT) || (func == FUNC_DIV)) && operandB[WIDTH-1];
    assign a_mag = a_neg ? -operandA : operandA;
    assign b_mag = b_neg ? -operandB : operandB;
    assign product = {acc, quo};

    mdlu_step #(.WIDTH(WIDTH)) u_step (
`ifdef MDLU_DIV_EN
        .is_div   (op_div),
`endif
        .acc      (acc),
        .quo      (quo),
        .opnd     (opnd),
        .acc_next (acc_step),
        .quo_next (quo_step)
    );

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: every output of this block gets a default first, otherwise a path
    // that skips an assignment would infer a latch.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (accept_mul)      state_next = MUL;
                else if (accept_div) state_next = DIV;
            end
            MUL, DIV: begin
                busy = 1'b1;
                if (last_step) state_next = FIX;
            end
            FIX: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign stall = busy || accept_mul || accept_div;

    assign resultOutput = (func == FUNC_MFHI) ? hi :
                          (func == FUNC_MFLO) ? lo : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            acc    <= '0;
            quo    <= '0;
            opnd   <= '0;
            neg_q  <= 1'b0;
            hi     <= '0;
            lo     <= '0;
`ifdef MDLU_DIV_EN
            op_div <= 1'b0;
            neg_r  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept_mul || accept_div) begin
                        cnt    <= '0;
                        acc    <= '0;
                        quo    <= accept_div ? a_mag : b_mag;
                        opnd   <= accept_div ? b_mag : a_mag;
                        neg_q  <= a_neg ^ b_neg;
`ifdef MDLU_DIV_EN
                        op_div <= accept_div;
                        neg_r  <= a_neg;
`endif
                    end else if (start && (func == FUNC_MTHI)) begin
                        hi <= operandA;
                    end else if (start && (func == FUNC_MTLO)) begin
                        lo <= operandA;
                    end
                end
                MUL, DIV: begin
                    acc <= acc_step;
                    quo <= quo_step;
                    cnt <= last_step ? '0 : cnt + CW'(1);
                end
                FIX: begin
`ifdef MDLU_DIV_EN
                    if (op_div) begin
                        lo <= neg_q ? -quo : quo;
                        hi <= neg_r ? -acc : acc;
                    end else begin
                        {hi, lo} <= neg_q ? -product : product;
                    end
`else
                    {hi, lo} <= neg_q ? -product : product;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdlu_sequencer.sv
// Self-checking bench for mdlu_sequencer: directed corner cases plus randomized
// operations checked against a 64-bit arithmetic reference model.
module tb_mdlu_sequencer;
    import mdlu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [5:0]   func;
    logic [W-1:0] operandA, operandB;
    logic         busy, stall, done;
    logic [W-1:0] resultOutput, hi, lo;

    int           total = 0;
    int           bad   = 0;
    logic [W-1:0] exp_hi, exp_lo;

    mdlu_sequencer #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .func         (func),
        .operandA     (operandA),
        .operandB     (operandB),
        .busy         (busy),
        .stall        (stall),
        .done         (done),
        .resultOutput (resultOutput),
        .hi           (hi),
        .lo           (lo)
    );

    always #5 clk = ~clk;

    // Architectural effect of one instruction on HI/LO, from plain arithmetic.
    function automatic void model(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                                  inout logic [W-1:0] mh, inout logic [W-1:0] ml);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (f)
            FUNC_MTHI: mh = a;
            FUNC_MTLO: ml = a;
            FUNC_MULT: begin
                p  = sa * sb;
                mh = p[63:32];
                ml = p[31:0];
            end
            FUNC_MULTU: begin
                p  = {32'b0, a} * {32'b0, b};
                mh = p[63:32];
                ml = p[31:0];
            end
            FUNC_DIVU: begin
                if (b == 0) begin
                    ml = '1;
                    mh = a;
                end else begin
                    ml = a / b;
                    mh = a % b;
                end
            end
            FUNC_DIV: begin
                if (b == 0) begin
                    mh = a;
                    ml = a[W-1] ? 32'd1 : 32'hFFFF_FFFF;
                end else begin
                    q  = sa / sb;
                    r  = sa % sb;
                    ml = q[31:0];
                    mh = r[31:0];
                end
            end
            default: ;
        endcase
    endfunction

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] corner [4];
        corner[0] = 32'h8000_0000;
        corner[1] = 32'hFFFF_FFFF;
        corner[2] = 32'h0000_0000;
        corner[3] = 32'h0000_0001;
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return 32'($urandom_range(0, 100));
            2:       return -32'($urandom_range(1, 100));
            default: return corner[$urandom_range(0, 3)];
        endcase
    endfunction

    // Full iterative operation: stall in start cycle, busy window, done timing, result.
    task automatic do_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        logic [W-1:0] eh, el;
        bit ok;
        eh = exp_hi;
        el = exp_lo;
        model(f, a, b, eh, el);
        @(negedge clk);
        start = 1'b1; func = f; operandA = a; operandB = b;
        #1;
        total++;
        if (stall !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s start_cycle: stall=%b busy=%b required stall=1 busy=0", tag, stall, busy);
        end
        @(negedge clk);
        start = 1'b0; func = FUNC_MFHI; operandA = $urandom; operandB = $urandom;
        ok = 1'b1;
        for (int n = 1; n <= W + 1; n++) begin
            #1;
            if (busy !== 1'b1 || stall !== 1'b1 || done !== 1'b0) ok = 1'b0;
            @(negedge clk);
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s busy_window: busy/stall not held high (or early done) for %0d cycles", tag, W + 1);
        end
        #1;
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || stall !== 1'b0) begin
            bad++;
            $display("FAIL %s done_cycle: done=%b busy=%b stall=%b required 1 0 0", tag, done, busy, stall);
        end
        total++;
        if (hi !== eh || lo !== el) begin
            bad++;
            $display("FAIL %s result: a=%h b=%h hi=%h lo=%h required hi=%h lo=%h", tag, a, b, hi, lo, eh, el);
        end
        total++;
        if (resultOutput !== eh) begin
            bad++;
            $display("FAIL %s mfhi: resultOutput=%h required %h", tag, resultOutput, eh);
        end
        @(negedge clk);
        #1;
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL %s done_pulse: done=%b one cycle later, required 0", tag, done);
        end
        exp_hi = eh;
        exp_lo = el;
    endtask

    task automatic do_move(input logic [5:0] f, input logic [W-1:0] a, input string tag);
        model(f, a, '0, exp_hi, exp_lo);
        @(negedge clk);
        start = 1'b1; func = f; operandA = a; operandB = $urandom;
        #1;
        total++;
        if (stall !== 1'b0) begin
            bad++;
            $display("FAIL %s stall: stall=%b required 0", tag, stall);
        end
        @(negedge clk);
        start = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin
            bad++;
            $display("FAIL %s write: busy=%b done=%b hi=%h lo=%h required 0 0 %h %h",
                     tag, busy, done, hi, lo, exp_hi, exp_lo);
        end
    endtask

    task automatic test_reset();
        func = FUNC_MFHI;
        #1;
        total++;
        if (hi !== '0 || lo !== '0 || busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0 || resultOutput !== '0) begin
            bad++;
            $display("FAIL reset_state: hi=%h lo=%h busy=%b done=%b stall=%b res=%h required all zero",
                     hi, lo, busy, done, stall, resultOutput);
        end
        exp_hi = '0;
        exp_lo = '0;
    endtask

    task automatic test_move_and_read();
        do_move(FUNC_MTHI, 32'h0000_1234, "mthi");
        func = FUNC_MFHI;
        #1;
        total++;
        if (resultOutput !== 32'h0000_1234) begin
            bad++;
            $display("FAIL mfhi_read: resultOutput=%h required 00001234", resultOutput);
        end
        do_move(FUNC_MTLO, 32'hCAFE_0001, "mtlo");
        func = FUNC_MFLO;
        #1;
        total++;
        if (resultOutput !== 32'hCAFE_0001) begin
            bad++;
            $display("FAIL mflo_read: resultOutput=%h required cafe0001", resultOutput);
        end
        func = FUNC_MULT;
        #1;
        total++;
        if (resultOutput !== '0) begin
            bad++;
            $display("FAIL other_read: resultOutput=%h required 0", resultOutput);
        end
    endtask

    task automatic test_multiply();
        logic [5:0] f;
        do_op(FUNC_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        do_op(FUNC_MULT, -32'd3, 32'd7, "mult_neg3x7");
        do_op(FUNC_MULT, 32'h8000_0000, 32'h8000_0000, "mult_minxmin");
        for (int i = 0; i < 8; i++) begin
            f = ($urandom_range(0, 1) == 0) ? FUNC_MULT : FUNC_MULTU;
            do_op(f, pick_operand(), pick_operand(), "mult_rand");
        end
    endtask

`ifdef MDLU_DIV_EN
    task automatic test_divide();
        logic [5:0] f;
        do_op(FUNC_DIV, -32'd7, 32'd2, "div_neg7by2");
        do_op(FUNC_DIVU, 32'd7, 32'd0, "divu_by0");
        do_op(FUNC_DIV, -32'd7, 32'd0, "div_neg_by0");
        do_op(FUNC_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_by_m1");
        for (int i = 0; i < 8; i++) begin
            f = ($urandom_range(0, 1) == 0) ? FUNC_DIV : FUNC_DIVU;
            do_op(f, pick_operand(), pick_operand(), "div_rand");
        end
    endtask
`else
    task automatic test_div_disabled();
        logic [5:0]   fl [2];
        logic [W-1:0] bl [2];
        bit ok;
        fl[0] = FUNC_DIV;  bl[0] = 32'd2;
        fl[1] = FUNC_DIVU; bl[1] = 32'd0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            start = 1'b1; func = fl[k]; operandA = 32'd10; operandB = bl[k];
            #1;
            total++;
            if (stall !== 1'b0) begin
                bad++;
                $display("FAIL div_off_stall: func=%h stall=%b required 0", fl[k], stall);
            end
            @(negedge clk);
            start = 1'b0;
            ok = 1'b1;
            for (int n = 0; n < W + 4; n++) begin
                #1;
                if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0) ok = 1'b0;
                @(negedge clk);
            end
            total++;
            if (!ok || hi !== exp_hi || lo !== exp_lo) begin
                bad++;
                $display("FAIL div_off_noop: func=%h hi=%h lo=%h required %h %h, no busy/done",
                         fl[k], hi, lo, exp_hi, exp_lo);
            end
        end
    endtask
`endif

    task automatic test_ignore_while_busy();
        logic [W-1:0] eh, el;
        bit seen;
        eh = exp_hi;
        el = exp_lo;
        model(FUNC_MULT, 32'd12345, -32'd678, eh, el);
        @(negedge clk);
        start = 1'b1; func = FUNC_MULT; operandA = 32'd12345; operandB = -32'd678;
        @(negedge clk);
        func = FUNC_MTLO; operandA = 32'h5A5A_5A5A;
        repeat (2) @(negedge clk);
        func = FUNC_MULTU; operandA = 32'd9; operandB = 32'd9;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < W + 5 && !seen; n++) begin
            #1;
            if (done === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL busy_ignore_done: done=0 after %0d cycles, required a pulse", W + 5);
        end
        start = 1'b1; func = FUNC_MTHI; operandA = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0;
        #1;
        total++;
        if (hi !== eh || lo !== el || done !== 1'b0) begin
            bad++;
            $display("FAIL busy_ignore_result: hi=%h lo=%h done=%b required %h %h 0", hi, lo, done, eh, el);
        end
        exp_hi = eh;
        exp_lo = el;
    endtask

    task automatic test_mid_reset();
        bit ok;
        do_move(FUNC_MTHI, 32'hAAAA_5555, "pre_reset_mthi");
        do_move(FUNC_MTLO, 32'h1357_9BDF, "pre_reset_mtlo");
        @(negedge clk);
        start = 1'b1; func = FUNC_MULT; operandA = -32'd5; operandB = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b0;
        #1;
        total++;
        if (hi !== '0 || lo !== '0 || busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_state: hi=%h lo=%h busy=%b done=%b stall=%b required all zero",
                     hi, lo, busy, done, stall);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        ok = 1'b1;
        for (int n = 0; n < W + 6; n++) begin
            #1;
            if (done !== 1'b0 || busy !== 1'b0 || hi !== '0 || lo !== '0) ok = 1'b0;
            @(negedge clk);
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL mid_reset_quiet: done/busy rose or HI/LO changed after reset, required quiet");
        end
        exp_hi = '0;
        exp_lo = '0;
        do_op(FUNC_MULTU, 32'd2, 32'd3, "post_reset_multu");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            do_op(FUNC_MULTU, $urandom, $urandom, "b2b_multu");
            do_move(FUNC_MTLO, $urandom, "b2b_mtlo");
        end
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        func = FUNC_MFHI;
        operandA = '0;
        operandB = '0;
        repeat (3) @(negedge clk);
        test_reset();
        reset = 1'b1;
        test_move_and_read();
        test_multiply();
`ifdef MDLU_DIV_EN
        test_divide();
`else
        test_div_disabled();
`endif
        test_ignore_while_busy();
        test_mid_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
